// File: rtl/flop_pipe_sched.sv
// Round-robin two-requester entrance to a DEPTH-stage valid/tag/data flop chain.
// Latency: accepted at edge k, out_valid after edge k+DEPTH-1; ready is combinational.
// Backpressure: out_valid && !out_ready freezes every stage (bubbles included) and drops both readies.
module flop_pipe_sched #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       req0_valid,
    input  logic [WIDTH-1:0]           req0_data,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic [WIDTH-1:0]           req1_data,
    output logic                       req1_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_src,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            stg_vld;
    logic [DEPTH-1:0][WIDTH-1:0] stg_dat;
    logic [DEPTH-1:0]            stg_src;
    logic                        rr_last;
    logic [OW-1:0]               occ;

    logic             advance;
    logic             accept_ok;
    logic             grant0;
    logic             grant1;
    logic             take;
    logic             leave;
    logic [WIDTH-1:0] in_dat;

    always_comb begin
        advance   = !(stg_vld[DEPTH-1] && !out_ready);
        // On contention the requester that did not win last time is served
        grant0    = req0_valid && (!req1_valid || rr_last);
        grant1    = req1_valid && (!req0_valid || !rr_last);
        accept_ok = advance && !flush && rst_n;
        req0_ready = grant0 && accept_ok;
        req1_ready = grant1 && accept_ok;
        take      = req0_ready || req1_ready;
        in_dat    = req1_ready ? req1_data : req0_data;
        leave     = stg_vld[DEPTH-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_vld <= '0;
            stg_dat <= '0;
            stg_src <= '0;
            rr_last <= 1'b1;
            occ     <= '0;
        end else if (flush) begin
            // Payload and tags are left stale; only validity matters after a flush
            stg_vld <= '0;
            occ     <= '0;
        end else if (advance) begin
            stg_vld <= {stg_vld[DEPTH-2:0], take};
            stg_dat <= {stg_dat[DEPTH-2:0], in_dat};
            stg_src <= {stg_src[DEPTH-2:0], req1_ready};
            occ     <= occ + OW'(take) - OW'(leave);
            if (take) begin
                rr_last <= req1_ready;
            end
        end
    end

    assign out_valid = stg_vld[DEPTH-1];
    assign out_data  = stg_dat[DEPTH-1];
    assign out_src   = stg_src[DEPTH-1];
    assign occupancy = occ;

endmodule

// File: tb/tb_flop_pipe_sched.sv
// Bench for flop_pipe_sched: fixed vector table, hand-written corner sequences, then random
// traffic checked against a queue-based pipeline model.
module tb_flop_pipe_sched;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int OW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst_n, flush;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_data, req1_data, out_data;
    logic             out_valid, out_src, out_ready;
    logic [OW-1:0]    occupancy;

    always #5 clk = ~clk;

    flop_pipe_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .occupancy(occupancy)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue index 0 is stage0, last index is the output stage
    typedef struct { bit v; logic [7:0] d; bit s; } ent_t;
    ent_t pipe[$];
    bit   m_rr;

    function automatic int m_occ();
        int n = 0;
        foreach (pipe[i]) if (pipe[i].v) n++;
        return n;
    endfunction

    task automatic step(input bit rn, input bit fl, input bit v0, input logic [7:0] d0,
                        input bit v1, input logic [7:0] d1, input bit ordy,
                        output bit ar0, output bit ar1, output bit aov,
                        output logic [7:0] aod, output bit aos, output int aocc);
        ent_t e;
        bit   adv, g0, g1, er0, er1;
        @(negedge clk);
        rst_n = rn; flush = fl; req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1; out_ready = ordy;
        #1;
        adv = !(pipe[DEPTH-1].v && !ordy);
        if (v0 && v1) begin g0 = (m_rr == 1'b1); g1 = (m_rr == 1'b0); end
        else begin g0 = v0; g1 = v1; end
        er0 = g0 && adv && !fl && rn;
        er1 = g1 && adv && !fl && rn;
        ar0 = req0_ready; ar1 = req1_ready;
        check("req0_ready", ar0, er0);
        check("req1_ready", ar1, er1);
        @(posedge clk);
        if (!rn) begin
            foreach (pipe[i]) pipe[i] = '{1'b0, 8'h00, 1'b0};
            m_rr = 1'b1;
        end else if (fl) begin
            foreach (pipe[i]) pipe[i].v = 1'b0;
        end else if (adv) begin
            e.v = er0 || er1;
            e.d = er1 ? d1 : d0;
            e.s = er1;
            void'(pipe.pop_back());
            pipe.push_front(e);
            if (e.v) m_rr = er1;
        end
        #1;
        aov = out_valid; aod = out_data; aos = out_src; aocc = int'(occupancy);
        check("out_valid", aov, pipe[DEPTH-1].v);
        if (pipe[DEPTH-1].v || !rn) begin
            check("out_data", aod, pipe[DEPTH-1].d);
            check("out_src", aos, pipe[DEPTH-1].s);
        end
        check("occupancy", aocc, m_occ());
        check("occ_bound", aocc <= DEPTH, 1);
    endtask

    typedef struct {
        bit rn, fl, v0; logic [7:0] d0; bit v1; logic [7:0] d1; bit ordy;
        bit r0, r1, ov; logic [7:0] od; bit os; int occ;
    } vec_t;

    function automatic vec_t mk(bit rn, bit fl, bit v0, logic [7:0] d0, bit v1, logic [7:0] d1,
                                bit ordy, bit r0, bit r1, bit ov, logic [7:0] od, bit os, int occ);
        vec_t t;
        t.rn = rn; t.fl = fl; t.v0 = v0; t.d0 = d0; t.v1 = v1; t.d1 = d1; t.ordy = ordy;
        t.r0 = r0; t.r1 = r1; t.ov = ov; t.od = od; t.os = os; t.occ = occ;
        return t;
    endfunction

    vec_t tbl[$];
    bit r0, r1, ov, os, prev_ov;
    logic [7:0] od;
    int occ;
    bit h0v, h1v;
    logic [7:0] h0d, h1d;

    initial begin
        for (int i = 0; i < DEPTH; i++) pipe.push_back('{1'b0, 8'h00, 1'b0});
        m_rr = 1'b1;
        rst_n = 1'b0; flush = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0; out_ready = 1'b1;

        //           rn fl v0 d0     v1 d1     ord r0 r1 ov od     os occ
        tbl.push_back(mk(0, 0, 1, 8'hA0, 1, 8'hB0, 1, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'hA0, 1, 8'hB0, 1, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 1, 8'hA0, 1, 8'hB0, 1, 1, 0, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 0, 1, 8'hA1, 1, 8'hB0, 1, 0, 1, 0, 8'h00, 0, 2));
        tbl.push_back(mk(1, 0, 1, 8'hA1, 1, 8'hB1, 1, 1, 0, 1, 8'hA0, 0, 3));
        tbl.push_back(mk(1, 0, 1, 8'hA2, 1, 8'hB1, 1, 0, 1, 1, 8'hB0, 1, 3));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'hA1, 0, 2));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'hB1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 1, 8'h11, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 0, 1, 8'h22, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 2));
        tbl.push_back(mk(1, 0, 1, 8'h33, 0, 8'h00, 1, 1, 0, 1, 8'h11, 0, 3));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h22, 0, 2));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h33, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 1, 8'h44, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 0, 1, 8'h55, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 2));
        tbl.push_back(mk(1, 1, 0, 8'h00, 1, 8'hC0, 1, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 8'hC0, 1, 0, 1, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'hC0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].rn, tbl[i].fl, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].ordy,
                 r0, r1, ov, od, os, occ);
            check($sformatf("vec%0d_r0", i), r0, tbl[i].r0);
            check($sformatf("vec%0d_r1", i), r1, tbl[i].r1);
            check($sformatf("vec%0d_ov", i), ov, tbl[i].ov);
            check($sformatf("vec%0d_occ", i), occ, tbl[i].occ);
            if (tbl[i].ov || !tbl[i].rn) begin
                check($sformatf("vec%0d_od", i), od, tbl[i].od);
                check($sformatf("vec%0d_os", i), os, tbl[i].os);
            end
        end

        // Backpressure: fill, stall five cycles with req1 pending, then drain
        step(1, 0, 1, 8'h01, 0, 8'h00, 1, r0, r1, ov, od, os, occ);
        check("bp_fill0", r0, 1);
        step(1, 0, 1, 8'h02, 0, 8'h00, 1, r0, r1, ov, od, os, occ);
        step(1, 0, 1, 8'h03, 0, 8'h00, 1, r0, r1, ov, od, os, occ);
        check("bp_full_occ", occ, 3);
        check("bp_full_od", od, 8'h01);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 8'h00, 1, 8'hD0, 0, r0, r1, ov, od, os, occ);
            check("bp_stall_r1", r1, 0);
            check("bp_stall_occ", occ, 3);
            check("bp_stall_od", od, 8'h01);
        end
        step(1, 0, 0, 8'h00, 1, 8'hD0, 1, r0, r1, ov, od, os, occ);
        check("bp_drain_accept", r1, 1);
        check("bp_drain_od1", od, 8'h02);
        check("bp_drain_occ", occ, 3);
        step(1, 0, 0, 8'h00, 0, 8'h00, 1, r0, r1, ov, od, os, occ);
        check("bp_drain_od2", od, 8'h03);
        step(1, 0, 0, 8'h00, 0, 8'h00, 1, r0, r1, ov, od, os, occ);
        check("bp_drain_od3", od, 8'hD0);
        check("bp_drain_os3", os, 1);
        step(1, 0, 0, 8'h00, 0, 8'h00, 1, r0, r1, ov, od, os, occ);
        check("bp_empty", ov, 0);

        // Bubbles: request on alternate cycles, output alternates once primed
        for (int i = 0; i < 12; i++) begin
            step(1, 0, (i % 2) == 0, 8'h60 + 8'(i), 0, 8'h00, 1, r0, r1, ov, od, os, occ);
            if (i >= 2) check("bubble_ov", ov, (i % 2) == 0);
            check("bubble_occ_le2", occ <= 2, 1);
        end

        // Random traffic with held requests, sporadic flush/reset and stalls
        h0v = 0; h1v = 0; h0d = '0; h1d = '0;
        for (int i = 0; i < 500; i++) begin
            if (!h0v) begin h0v = $urandom_range(0, 2) != 0; h0d = 8'($urandom); end
            if (!h1v) begin h1v = $urandom_range(0, 2) != 0; h1d = 8'($urandom); end
            step($urandom_range(0, 59) != 0, $urandom_range(0, 24) == 0, h0v, h0d, h1v, h1d,
                 $urandom_range(0, 3) != 0, r0, r1, ov, od, os, occ);
            check("rand_one_ready", r0 && r1, 0);
            if (r0) h0v = 0;
            if (r1) h1v = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
